// File: rtl/gan_param_loader.sv
// Framed serial loader for the GAN parameter bus: hunts for a sync word, stages the
// payload in a shadow bank, verifies a running checksum and commits atomically.
module gan_param_loader #(
  parameter int                WIDTH     = 32,
  parameter int                NUM_WORDS = 77,
  parameter logic [WIDTH-1:0]  SYNC_WORD = 32'hA5A5_0077
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       abort,
  output logic [NUM_WORDS*WIDTH-1:0] param_bus,
  output logic                       bank_valid,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       frame_err
);

  localparam int CW = $clog2(NUM_WORDS);
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic [WIDTH-1:0]           sum;
  logic [NUM_WORDS*WIDTH-1:0] shadow;
  logic                       xfer;

  assign xfer = s_valid & s_ready;

  // param_bus is only ever loaded from shadow in COMMIT, so consumers never see a partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sum        <= '0;
      shadow     <= '0;
      param_bus  <= '0;
      bank_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      s_ready    <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        s_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (xfer && s_data == SYNC_WORD) begin
              state <= LOAD;
              cnt   <= '0;
              sum   <= '0;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            if (xfer) begin
              shadow[cnt*WIDTH +: WIDTH] <= s_data;
              sum <= sum + s_data;
              if (cnt == LAST) begin
                state <= CHECK;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          CHECK: begin
            if (xfer) begin
              if (s_data == sum) begin
                state   <= COMMIT;
                s_ready <= 1'b0;
              end else begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
              end
            end
          end
          COMMIT: begin
            param_bus  <= shadow;
            bank_valid <= 1'b1;
            frame_done <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
            s_ready    <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gan_param_loader.sv
// Self-checking bench for gan_param_loader: directed frames plus randomized payloads,
// gaps and checksum corruption, checked against an array model of the active bank.
module tb_gan_param_loader;

  localparam int          WIDTH     = 32;
  localparam int          NUM_WORDS = 77;
  localparam logic [31:0] SYNC      = 32'hA5A5_0077;

  logic                       clk;
  logic                       rst;
  logic                       s_valid;
  logic                       s_ready;
  logic [WIDTH-1:0]           s_data;
  logic                       abort;
  logic [NUM_WORDS*WIDTH-1:0] param_bus;
  logic                       bank_valid;
  logic                       busy;
  logic                       frame_done;
  logic                       frame_err;

  gan_param_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .abort      (abort),
    .param_bus  (param_bus),
    .bank_valid (bank_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_bank [NUM_WORDS];
  bit          model_valid;
  logic [31:0] payload    [NUM_WORDS];

  task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_bit(string tag, logic observed, logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] bus_word(int k);
    return param_bus[k*WIDTH +: WIDTH];
  endfunction

  // Compares the first differing word (or word 0 when all agree) against the model bank.
  task automatic check_bus(string tag);
    int idx = 0;
    for (int k = NUM_WORDS - 1; k >= 0; k--)
      if (bus_word(k) !== model_bank[k]) idx = k;
    check_output({tag, "_bus"}, bus_word(idx), model_bank[idx]);
    check_bit({tag, "_bank_valid"}, bank_valid, model_valid);
  endtask

  function automatic logic [31:0] payload_sum();
    longint total = 0;
    for (int k = 0; k < NUM_WORDS; k++) total += longint'(payload[k]);
    return total[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word after a random idle gap and holds it until it is accepted.
  task automatic apply_stimulus(logic [31:0] word, int max_gap);
    int waited = 0;
    bit done   = 0;
    int gap    = $urandom_range(0, max_gap);
    s_valid = 1'b0;
    s_data  = SYNC;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = word;
    while (!done) begin
      @(negedge clk);
      if (s_ready) done = 1;
      else if (++waited > 20) begin
        check_bit("ready_timeout", s_ready, 1'b1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic run_frame(string tag, logic [31:0] checksum, int max_gap, bit abort_commit);
    bit good   = (checksum == payload_sum());
    bit commit = good && !abort_commit;
    apply_stimulus(SYNC, max_gap);
    for (int k = 0; k < NUM_WORDS; k++) apply_stimulus(payload[k], max_gap);
    check_bus({tag, "_hold"});
    apply_stimulus(checksum, max_gap);
    check_bit({tag, "_err_n"}, frame_err, !good);
    check_bit({tag, "_done_n"}, frame_done, 1'b0);
    check_bit({tag, "_busy_n"}, busy, good);
    if (abort_commit) abort = 1'b1;
    tick();
    abort = 1'b0;
    if (commit) begin
      model_bank  = payload;
      model_valid = 1'b1;
    end
    check_bit({tag, "_done_n1"}, frame_done, commit);
    check_bit({tag, "_err_n1"}, frame_err, 1'b0);
    check_bit({tag, "_busy_n1"}, busy, 1'b0);
    check_bit({tag, "_ready_n1"}, s_ready, 1'b1);
    check_bus(tag);
    tick();
    check_bit({tag, "_done_n2"}, frame_done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    abort   = 1'b0;
    model_valid = 1'b0;
    for (int k = 0; k < NUM_WORDS; k++) model_bank[k] = '0;
    repeat (3) @(posedge clk);
    #2;
    check_bus("reset");
    check_bit("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_bit("reset_ready", s_ready, 1'b1);
    check_bit("reset_done", frame_done, 1'b0);
    check_bit("reset_err", frame_err, 1'b0);

    $display("[TB] T2 good frame");
    for (int k = 0; k < NUM_WORDS; k++) payload[k] = 32'(k + 1);
    run_frame("t2", 32'd3003, 0, 0);

    $display("[TB] T3 bad checksum");
    for (int k = 0; k < NUM_WORDS; k++) payload[k] = 32'(k + 100);
    run_frame("t3", 32'd0, 0, 0);

    $display("[TB] T4 hunt and backpressure");
    apply_stimulus(32'h0000_1234, 2);
    apply_stimulus(32'h0000_DEAD, 2);
    check_bit("t4_junk_busy", busy, 1'b0);
    for (int k = 0; k < NUM_WORDS; k++) payload[k] = $urandom;
    run_frame("t4", payload_sum(), 3, 0);

    $display("[TB] T5 abort then wrap");
    for (int k = 0; k < NUM_WORDS; k++) payload[k] = 32'h1111_0000 + 32'(k);
    apply_stimulus(SYNC, 1);
    for (int k = 0; k < 40; k++) apply_stimulus(payload[k], 1);
    s_valid = 1'b1;
    s_data  = payload[40];
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    check_bit("t5_abort_busy", busy, 1'b0);
    check_bit("t5_abort_done", frame_done, 1'b0);
    check_bit("t5_abort_err", frame_err, 1'b0);
    check_bus("t5_abort");
    for (int k = 0; k < NUM_WORDS; k++) payload[k] = 32'hFFFF_FFFF;
    run_frame("t5", 32'hFFFF_FFB3, 1, 0);

    $display("[TB] T6 sync word inside payload");
    for (int k = 0; k < NUM_WORDS; k++) payload[k] = $urandom;
    payload[10] = SYNC;
    run_frame("t6", payload_sum(), 1, 0);

    $display("[TB] abort during commit");
    for (int k = 0; k < NUM_WORDS; k++) payload[k] = $urandom;
    run_frame("t7", payload_sum(), 0, 1);

    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      logic [31:0] cs;
      for (int k = 0; k < NUM_WORDS; k++) payload[k] = $urandom;
      cs = payload_sum();
      if ($urandom_range(0, 2) == 0) cs = cs ^ (32'd1 << $urandom_range(0, 31));
      run_frame("rand", cs, 2, 0);
    end

    $display("[TB] T1 reset mid-frame");
    apply_stimulus(SYNC, 0);
    for (int k = 0; k < 20; k++) apply_stimulus($urandom, 0);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NUM_WORDS; k++) model_bank[k] = '0;
    model_valid = 1'b0;
    check_bus("t1");
    check_bit("t1_busy", busy, 1'b0);
    check_bit("t1_done", frame_done, 1'b0);
    check_bit("t1_err", frame_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_bit("t1_ready", s_ready, 1'b1);
    check_bit("t1_busy_rel", busy, 1'b0);
    for (int k = 0; k < NUM_WORDS; k++) payload[k] = $urandom;
    run_frame("t1_recover", payload_sum(), 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
